mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_beat_ctr.sv | 39 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        RD_DRAIN = 2'd2,
        WRITE    = 2'd3
    } arb_state_t;

    localparam int   BEAT_BYTES = 4;
    localparam logic RD         = 1'b0;
    localparam logic WR         = 1'b1;

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// Beat counter with last-beat flag, plus the per-beat write wait counter.
module mem_arb_beat_ctr #(
    parameter int WR_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       beat_adv,
    input  logic       wait_en,
    input  logic [3:0] len,
    output logic [3:0] beat_cnt,
    output logic       last_beat,
    output logic       timeout
);

    localparam int WAIT_W = $clog2(WR_TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // start wins so both counters sit at zero whenever the arbiter is idle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else if (start) begin
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else if (beat_adv) begin
            beat_cnt <= beat_cnt + 4'd1;
            wait_cnt <= '0;
        end else if (wait_en && !timeout) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign last_beat = (beat_cnt == len);
    assign timeout   = (wait_cnt == WAIT_W'(WR_TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting a single memory port to a read or a write burst requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 7,
    parameter int WR_TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   rd_req,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [3:0]             rd_len,
    output logic                   rd_grant,
    output logic                   rd_beat,
    output logic                   rd_done,
    input  logic                   wr_req,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [3:0]             wr_len,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_grant,
    output logic                   wr_beat,
    output logic                   wr_done,
    output logic                   wr_err,
    output logic                   mem_cs,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_waddr,
    output logic [RADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_wfinish
);

    arb_state_t            state;
    logic                  last_served;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [3:0]            burst_len;
    logic [3:0]            beat_cnt;
    logic                  last_beat;
    logic                  timeout;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  rd_pick;
    logic                  wr_pick;
    logic                  wr_fin;
    logic                  wr_abort;
    logic                  unused_rdata;

    // read data goes straight to the read requester; only its timing is tracked here
    assign unused_rdata = ^mem_rdata;

    always_comb begin
        rd_pick  = rd_req && (!wr_req || last_served == WR);
        wr_pick  = wr_req && !rd_pick;
        wr_fin   = (state == WRITE) && mem_wfinish;
        wr_abort = (state == WRITE) && !mem_wfinish && timeout;
    end

    assign beat_addr = start_addr + ADDR_WIDTH'(beat_cnt) * ADDR_WIDTH'(BEAT_BYTES);

    mem_arb_beat_ctr #(
        .WR_TIMEOUT (WR_TIMEOUT)
    ) u_beat_ctr (
        .clk       (clk),
        .clr       (clr),
        .start     (state == IDLE),
        .beat_adv  (((state == READ) || wr_fin) && !last_beat),
        .wait_en   (state == WRITE),
        .len       (burst_len),
        .beat_cnt  (beat_cnt),
        .last_beat (last_beat),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            last_served <= WR;
            start_addr  <= '0;
            burst_len   <= '0;
            rd_grant    <= 1'b0;
            wr_grant    <= 1'b0;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_pick) begin
                        state       <= READ;
                        start_addr  <= rd_addr;
                        burst_len   <= rd_len;
                        last_served <= RD;
                        rd_grant    <= 1'b1;
                        mem_cs      <= 1'b1;
                    end else if (wr_pick) begin
                        state       <= WRITE;
                        start_addr  <= wr_addr;
                        burst_len   <= wr_len;
                        last_served <= WR;
                        wr_grant    <= 1'b1;
                        mem_cs      <= 1'b1;
                        mem_we      <= 1'b1;
                    end
                end
                READ: begin
                    if (last_beat) begin
                        state  <= RD_DRAIN;
                        mem_cs <= 1'b0;
                    end
                end
                RD_DRAIN: begin
                    state    <= IDLE;
                    rd_grant <= 1'b0;
                end
                WRITE: begin
                    if ((wr_fin && last_beat) || wr_abort) begin
                        state    <= IDLE;
                        wr_grant <= 1'b0;
                        mem_cs   <= 1'b0;
                        mem_we   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rd_beat trails each presented address by one cycle; the last one lands in RD_DRAIN
    assign rd_beat   = ((state == READ) && (beat_cnt != 4'd0)) || (state == RD_DRAIN);
    assign rd_done   = (state == RD_DRAIN);
    assign wr_beat   = wr_fin;
    assign wr_done   = wr_fin && last_beat;
    assign wr_err    = wr_abort;
    assign mem_raddr = (state == READ)  ? beat_addr[RADDR_WIDTH-1:0] : '0;
    assign mem_waddr = (state == WRITE) ? beat_addr : '0;
    assign mem_wdata = (state == WRITE) ? wr_data : '0;

endmodule
